// File: rtl/int_to_float_arbiter.sv
// int_to_float_arbiter
//
// Shares a single int_to_float converter between N requesters. A round-robin
// arbiter picks one requester, takes its 32-bit signed operand, hands it to
// the converter, collects the IEEE single-precision result and returns it to
// the same requester. Only one conversion is in flight at any time.
//
// Handshake: every channel (req_a, rsp_z, conv_a, conv_z) moves data on a
// rising clk edge where stb and ack are both 1. The strobing side holds data
// and stb steady until that edge; the acknowledging side may raise ack at any
// time and drops it on the transfer edge.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_a        N packed operands, requester i at [32*i+31:32*i]
//   req_a_stb    per-requester operand strobe
//   req_a_ack    per-requester operand acknowledge (only the granted bit)
//   rsp_z        shared result bus, qualified by rsp_z_stb
//   rsp_z_stb    per-requester result strobe (only the granted bit)
//   rsp_z_ack    per-requester result acknowledge
//   conv_a*      operand channel towards the converter
//   conv_z*      result channel from the converter
//   grant        index of the requester being served
//   busy         high in every state except ARB
//   state        current FSM state, for observation
module int_to_float_arbiter #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*32-1:0] req_a,
    input  logic [N-1:0]    req_a_stb,
    output logic [N-1:0]    req_a_ack,
    output logic [31:0]     rsp_z,
    output logic [N-1:0]    rsp_z_stb,
    input  logic [N-1:0]    rsp_z_ack,
    output logic [31:0]     conv_a,
    output logic            conv_a_stb,
    input  logic            conv_a_ack,
    input  logic [31:0]     conv_z,
    input  logic            conv_z_stb,
    output logic            conv_z_ack,
    output logic [GW-1:0]   grant,
    output logic            busy,
    output logic [2:0]      state
);

    localparam logic [2:0] ST_ARB  = 3'd0;
    localparam logic [2:0] ST_GET  = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_RECV = 3'd3;
    localparam logic [2:0] ST_PUT  = 3'd4;

    logic [GW-1:0] last;
    logic [31:0]   a_reg;
    logic [31:0]   z_reg;
    logic [GW-1:0] next_grant;
    logic          any_req;
    logic [GW:0]   cand;

    // Round-robin pick: scan (last+1) .. (last+N) modulo N and take the first
    // strobing requester. cand is one bit wider so the wrap can be done with a
    // single conditional subtract, which also works when N is not a power of 2.
    always_comb begin
        next_grant = '0;
        any_req    = 1'b0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, last} + (GW+1)'(i);
            if (cand >= (GW+1)'(N)) begin
                cand = cand - (GW+1)'(N);
            end
            if (!any_req && req_a_stb[cand[GW-1:0]]) begin
                any_req    = 1'b1;
                next_grant = cand[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ARB;
            req_a_ack  <= '0;
            rsp_z_stb  <= '0;
            conv_a_stb <= 1'b0;
            conv_z_ack <= 1'b0;
            grant      <= '0;
            last       <= GW'(N-1);
            busy       <= 1'b0;
            rsp_z      <= '0;
            conv_a     <= '0;
            a_reg      <= '0;
            z_reg      <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (any_req) begin
                        grant <= next_grant;
                        busy  <= 1'b1;
                        state <= ST_GET;
                    end
                end
                // Ack is raised on the first GET edge; the operand is taken
                // on the edge where the registered ack meets the strobe.
                ST_GET: begin
                    req_a_ack[grant] <= 1'b1;
                    if (req_a_ack[grant] && req_a_stb[grant]) begin
                        a_reg            <= req_a[int'(grant)*32 +: 32];
                        req_a_ack[grant] <= 1'b0;
                        state            <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    conv_a     <= a_reg;
                    conv_a_stb <= 1'b1;
                    if (conv_a_stb && conv_a_ack) begin
                        conv_a_stb <= 1'b0;
                        state      <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    conv_z_ack <= 1'b1;
                    if (conv_z_ack && conv_z_stb) begin
                        z_reg      <= conv_z;
                        conv_z_ack <= 1'b0;
                        state      <= ST_PUT;
                    end
                end
                // rsp_z keeps its value after PUT; requesters qualify it
                // with their own strobe bit.
                ST_PUT: begin
                    rsp_z            <= z_reg;
                    rsp_z_stb[grant] <= 1'b1;
                    if (rsp_z_stb[grant] && rsp_z_ack[grant]) begin
                        rsp_z_stb[grant] <= 1'b0;
                        last             <= grant;
                        busy             <= 1'b0;
                        state            <= ST_ARB;
                    end
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float_arbiter.sv
// Testbench for int_to_float_arbiter: requester drivers, a behavioural
// converter, an auto-acking response side, a round-robin reference model
// with an expected-result queue, directed steps and a randomized phase.
module tb_int_to_float_arbiter;

    localparam int N  = 4;
    localparam int GW = 2;
    localparam int W  = 32 + GW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*32-1:0] req_a      = '0;
    logic [N-1:0]    req_a_stb  = '0;
    logic [N-1:0]    req_a_ack;
    logic [31:0]     rsp_z;
    logic [N-1:0]    rsp_z_stb;
    logic [N-1:0]    rsp_z_ack  = '0;
    logic [31:0]     conv_a;
    logic            conv_a_stb;
    logic            conv_a_ack = 1'b0;
    logic [31:0]     conv_z     = '0;
    logic            conv_z_stb = 1'b0;
    logic            conv_z_ack;
    logic [GW-1:0]   grant;
    logic            busy;
    logic [2:0]      state;

    int_to_float_arbiter #(.N(N), .GW(GW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
        .rsp_z(rsp_z), .rsp_z_stb(rsp_z_stb), .rsp_z_ack(rsp_z_ack),
        .conv_a(conv_a), .conv_a_stb(conv_a_stb), .conv_a_ack(conv_a_ack),
        .conv_z(conv_z), .conv_z_stb(conv_z_stb), .conv_z_ack(conv_z_ack),
        .grant(grant), .busy(busy), .state(state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference int32 -> binary32 conversion, round to nearest even.
    function automatic logic [31:0] i2f(input logic [31:0] v);
        logic [31:0] mag;
        logic [24:0] mt;
        int e;
        if (v == 32'd0) return 32'd0;
        mag = v[31] ? (~v + 32'd1) : v;
        e = 31;
        while (!mag[31]) begin
            mag = mag << 1;
            e--;
        end
        mt = {1'b0, mag[31:8]};
        if (mag[7] && ((|mag[6:0]) || mag[8])) mt = mt + 25'd1;
        if (mt[24]) begin
            mt = mt >> 1;
            e++;
        end
        return {v[31], 8'(e + 127), mt[22:0]};
    endfunction

    // ---------------- requester drivers ----------------
    int          req_total[N];
    int          req_done[N];
    logic [31:0] req_val[N];
    bit          req_rand[N];
    int          rsp_hold[N];
    int          a_delay = 0;
    int          z_delay = 0;

    task automatic send(input int i, input logic [31:0] v, input int cnt, input bit rnd);
        req_val[i]   = v;
        req_rand[i]  = rnd;
        req_total[i] = req_total[i] + cnt;
    endtask

    function automatic bit pending_any();
        for (int i = 0; i < N; i++) if (req_total[i] != req_done[i]) return 1'b1;
        return 1'b0;
    endfunction

    always begin : req_driver
        logic [N-1:0] xfer;
        @(posedge clk);
        xfer = req_a_stb & req_a_ack;
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                req_done[i]++;
                if (req_total[i] != req_done[i])
                    req_a[i*32 +: 32] = req_rand[i] ? $urandom : req_val[i];
                else
                    req_a_stb[i] = 1'b0;
            end else if (!req_a_stb[i] && req_total[i] != req_done[i]) begin
                req_a[i*32 +: 32] = req_rand[i] ? $urandom : req_val[i];
                req_a_stb[i] = 1'b1;
            end
        end
    end

    always begin : rsp_driver
        int h_cnt[N];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rsp_z_stb[i]) begin
                rsp_z_ack[i] = 1'b0;
                h_cnt[i]     = 0;
            end else if (!rsp_z_ack[i]) begin
                if (h_cnt[i] >= rsp_hold[i]) rsp_z_ack[i] = 1'b1;
                else h_cnt[i]++;
            end
        end
    end

    // ---------------- converter model ----------------
    always begin : conv_model
        logic        ax, zx, r;
        logic [31:0] a_cap;
        logic [31:0] c_op;
        bit          c_busy;
        int          c_cnt, a_wait;
        @(posedge clk);
        ax = conv_a_stb & conv_a_ack;
        zx = conv_z_stb & conv_z_ack;
        a_cap = conv_a;
        r = rst;
        #1;
        if (r) begin
            conv_a_ack = 1'b0;
            conv_z_stb = 1'b0;
            c_busy = 1'b0;
            a_wait = 0;
        end else begin
            if (zx) conv_z_stb = 1'b0;
            if (ax) begin
                conv_a_ack = 1'b0;
                a_wait = 0;
                c_op = a_cap;
                c_busy = 1'b1;
                c_cnt = z_delay;
            end else if (conv_a_stb && !conv_a_ack && !c_busy && !conv_z_stb) begin
                if (a_wait >= a_delay) conv_a_ack = 1'b1;
                else a_wait++;
            end
            if (c_busy) begin
                if (c_cnt == 0) begin
                    conv_z = i2f(c_op);
                    conv_z_stb = 1'b1;
                    c_busy = 1'b0;
                end else begin
                    c_cnt--;
                end
            end
        end
    end

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0] exp_q[$];
    int m_last  = N - 1;
    int m_grant = 0;

    always begin : monitor
        logic [N-1:0]    ax, zx, stb_s;
        logic [N*32-1:0] a_s;
        logic [31:0]     z_s;
        logic            busy_s, r;
        logic [W-1:0]    e;
        int eg, j;
        @(posedge clk);
        ax = req_a_stb & req_a_ack;
        zx = rsp_z_stb & rsp_z_ack;
        stb_s = req_a_stb;
        a_s = req_a;
        z_s = rsp_z;
        busy_s = busy;
        r = rst;
        #1;
        if (r) begin
            exp_q.delete();
            m_last = N - 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ax[i]) begin
                    check("op_requester", 32'(i), 32'(m_grant));
                    exp_q.push_back({GW'(i), i2f(a_s[i*32 +: 32])});
                end
            end
            for (int i = 0; i < N; i++) begin
                if (zx[i]) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_requester", 32'(i), 32'(e[W-1:32]));
                        check("rsp_value", z_s, e[31:0]);
                    end
                    m_last = i;
                end
            end
            if (!busy_s && busy) begin
                eg = N;
                for (int d = 1; d <= N; d++) begin
                    j = (m_last + d) % N;
                    if (eg == N && stb_s[j]) eg = j;
                end
                m_grant = eg;
                check("grant", 32'(grant), 32'(eg));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("ack_onehot0", 32'($countones(req_a_ack) <= 1), 32'd1);
            check("rsp_stb_onehot0", 32'($countones(rsp_z_stb) <= 1), 32'd1);
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed steps ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (rsp_z_stb == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", 32'(rsp_z_stb != '0), 32'd1);
    endtask

    task automatic wait_rsp_low(input int budget);
        int n = 0;
        while (rsp_z_stb != '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rsp_dropped", 32'(rsp_z_stb), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || rsp_z_stb != '0 || req_a_stb != '0 || pending_any()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy || rsp_z_stb != '0 || req_a_stb != '0 || pending_any()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : main
        int n;
        logic [N-1:0] mask;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_a_ack", 32'(req_a_ack), 32'd0);
        check("rst_rsp_z_stb", 32'(rsp_z_stb), 32'd0);
        check("rst_conv_a_stb", 32'(conv_a_stb), 32'd0);
        check("rst_conv_z_ack", 32'(conv_z_ack), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        rst = 1'b0;

        // Single request
        send(0, 32'd1, 1, 1'b0);
        wait_rsp(100);
        check("single_stb", 32'(rsp_z_stb), 32'b0001);
        check("single_z", rsp_z, 32'h3F80_0000);
        wait_idle(100);
        check("single_busy", 32'(busy), 32'd0);

        // Simultaneous requests 0 and 2 right after reset
        do_reset();
        send(0, -32'sd2, 1, 1'b0);
        send(2, 32'd100, 1, 1'b0);
        wait_rsp(100);
        check("simul_first_stb", 32'(rsp_z_stb), 32'b0001);
        check("simul_first_z", rsp_z, 32'hC000_0000);
        wait_rsp_low(100);
        wait_rsp(100);
        check("simul_second_stb", 32'(rsp_z_stb), 32'b0100);
        check("simul_second_z", rsp_z, 32'h42C8_0000);
        wait_idle(100);

        // Fairness between requesters 1 and 3
        do_reset();
        send(1, 32'd7, 2, 1'b0);
        send(3, 32'd7, 2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(100);
            check("fair_stb", 32'(rsp_z_stb), (k % 2 == 0) ? 32'b0010 : 32'b1000);
            check("fair_z", rsp_z, 32'h40E0_0000);
            wait_rsp_low(100);
        end
        wait_idle(100);

        // Result backpressure on requester 0
        rsp_hold[0] = 20;
        send(0, 32'd12345, 1, 1'b0);
        wait_rsp(100);
        send(1, 32'd5, 1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            check("stall_stb", 32'(rsp_z_stb), 32'b0001);
            check("stall_z", rsp_z, 32'h4640_E400);
            check("stall_req1_ack", 32'(req_a_ack[1]), 32'd0);
            @(negedge clk);
        end
        rsp_hold[0] = 0;
        wait_rsp_low(100);
        wait_rsp(100);
        check("after_stall_stb", 32'(rsp_z_stb), 32'b0010);
        check("after_stall_z", rsp_z, 32'h40A0_0000);
        wait_idle(100);

        // Converter delays its operand ack
        a_delay = 10;
        send(2, 32'd0, 1, 1'b0);
        n = 0;
        while (!conv_a_stb && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            check("conv_stall_stb", 32'(conv_a_stb), 32'd1);
            check("conv_stall_a", conv_a, 32'd0);
            @(negedge clk);
        end
        a_delay = 0;
        wait_rsp(100);
        check("conv_stall_rsp_stb", 32'(rsp_z_stb), 32'b0100);
        check("conv_stall_rsp_z", rsp_z, 32'd0);
        wait_idle(100);

        // Reset while waiting for the converter result
        z_delay = 30;
        send(1, 32'd42, 1, 1'b0);
        n = 0;
        while (!conv_z_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("recv_reached", 32'(conv_z_ack), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rrst_req_a_ack", 32'(req_a_ack), 32'd0);
        check("rrst_rsp_z_stb", 32'(rsp_z_stb), 32'd0);
        check("rrst_conv_a_stb", 32'(conv_a_stb), 32'd0);
        check("rrst_conv_z_ack", 32'(conv_z_ack), 32'd0);
        check("rrst_busy", 32'(busy), 32'd0);
        check("rrst_state", 32'(state), 32'd0);
        rst = 1'b0;
        z_delay = 0;
        send(3, -32'sd7, 1, 1'b0);
        wait_rsp(100);
        check("rrst_rsp_stb", 32'(rsp_z_stb), 32'b1000);
        check("rrst_rsp_z", rsp_z, 32'hC0E0_0000);
        check("rrst_grant", 32'(grant), 32'd3);
        wait_idle(100);

        // Randomized traffic against the reference model
        for (int it = 0; it < 30; it++) begin
            a_delay = $urandom_range(0, 3);
            z_delay = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) rsp_hold[i] = $urandom_range(0, 2);
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (mask[i]) send(i, 32'd0, $urandom_range(1, 3), 1'b1);
            wait_idle(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_to_float_arbiter.md
Name: int_to_float_arbiter

Overview:
- Shares one int_to_float converter between N requesters using round-robin arbitration.
- Each requester uses its own stb/ack channel to send a 32-bit signed integer and to receive the 32-bit IEEE single-precision result.
- The arbiter sits between the requester channels and the converter's input_a/output_z channels.
- Exactly one conversion is in flight at a time. A result is always returned to the requester that issued it.

Parameters:
- N, 4, number of requesters (2..8).
- GW, 2, grant index width; must satisfy 2**GW >= N.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_a  in  N*32  request operands; requester i occupies bits [32*i+31:32*i]
- req_a_stb  in  N  per-requester operand strobe
- req_a_ack  out  N  per-requester operand acknowledge
- rsp_z  out  32  result bus, shared by all requesters
- rsp_z_stb  out  N  per-requester result strobe
- rsp_z_ack  in  N  per-requester result acknowledge
- conv_a  out  32  operand to converter input_a
- conv_a_stb  out  1  to converter input_a_stb
- conv_a_ack  in  1  from converter input_a_ack
- conv_z  in  32  from converter output_z
- conv_z_stb  in  1  from converter output_z_stb
- conv_z_ack  out  1  to converter output_z_ack
- grant  out  GW  index of the requester currently being served
- busy  out  1  high in every state except ARB

Behaviour:
- Transfer rule on every channel: data moves on a rising clk edge where stb and ack are both 1. The strobing side holds data and stb until that edge.
- All outputs are registered.
- Reset: state=ARB, req_a_ack=0, rsp_z_stb=0, conv_a_stb=0, conv_z_ack=0, grant=0, last=N-1, busy=0.
  - Reset takes effect in any state and overrides all other assignments in that cycle.
  - Any in-flight operand or result is discarded.
- ARB: if any req_a_stb is 1, grant is the first requester with stb=1 scanning from (last+1) mod N upward, wrapping at N; go to GET. Otherwise stay in ARB.
- GET:
  - Drive req_a_ack[grant]=1.
  - On the transfer edge, latch req_a slice grant into the a register, clear the ack, go to SEND.
  - Only the granted requester's ack may ever be 1.
- SEND:
  - Drive conv_a=a and conv_a_stb=1.
  - On the transfer edge (conv_a_stb && conv_a_ack), clear the strobe and go to RECV.
- RECV:
  - Drive conv_z_ack=1.
  - On the transfer edge, latch conv_z into the z register, clear the ack, go to PUT.
- PUT:
  - Drive rsp_z=z and rsp_z_stb[grant]=1. All other rsp_z_stb bits are 0.
  - On the transfer edge, clear the strobe, set last=grant, go to ARB.
- rsp_z holds its last value outside PUT. Requesters must qualify it with their own strobe.
- Minimum cycles excluding converter latency: ARB 1, GET 2, SEND 2, RECV 2, PUT 2.
- Back-to-back service: a requester whose stb stays high is re-arbitrated in the ARB cycle that follows its PUT.
- Fairness: with k requesters continuously asserting stb, each is served exactly once per k consecutive grants.
- A request that arrives while busy waits in its stb. Nothing is queued internally.
- An unacknowledged rsp_z_stb stalls the arbiter indefinitely; this is intended backpressure.
- grant is stable from ARB exit until the next ARB exit.

Test Plan:
- Single request: requester 0 sends 1 → rsp_z_stb[0] asserts with rsp_z=0x3F800000; no other strobe asserts; busy drops after ack.
- Simultaneous requests from requesters 0 and 2 with values -2 and 100, right after reset:
  - Requester 0 is served first with 0xC0000000.
  - Requester 2 is served next with 0x42C80000.
- Fairness: requesters 1 and 3 hold stb continuously, each sending 7 → grant sequence 1,3,1,3 over four transactions; every result is 0x40E00000.
- Result backpressure: rsp_z_ack[0] held low for 20 cycles after rsp_z_stb[0] rises →
  - rsp_z and the strobe stay stable for those 20 cycles.
  - Requester 1's stb=1 is not acked during the stall.
  - Requester 1 is granted after the ack.
- Converter stall: the converter model delays conv_a_ack by 10 cycles → conv_a=0x00000000 and conv_a_stb are held throughout; the final result is 0x00000000 on the correct requester.
- Reset in RECV:
  - In the cycle after rst=1, all strobes and acks are 0, state is ARB, busy=0.
  - The next request from requester 3 is granted as if from power-up.
  - rsp_z_stb[3] asserts with the correct conversion.
